// File: rtl/kpn_fifo_channel.sv
// -----------------------------------------------------------------------------
// kpn_fifo_channel
//
// Bounded FIFO channel carrying tokens between two Kahn-process-network
// processes. A producer pushes with a valid/ready handshake, and a consumer
// pops the same way. Reads block while the channel is empty, and writes block
// while it is full. The channel can come out of reset already holding a number
// of identical seed tokens, so that it can close a feedback loop.
//
// Parameters
//   DATA_WIDTH   token width in bits
//   DEPTH        capacity in tokens (a power of two, >= 2)
//   ADDR_WIDTH   log2(DEPTH)
//   INIT_TOKENS  tokens present after reset (0..DEPTH)
//   INIT_VALUE   value of each seed token
//
// Ports
//   clk           in   rising-edge clock
//   reset         in   asynchronous assert, synchronous release, active high
//   entry_1       in   token offered by the producer
//   entry_valid   in   producer offers entry_1 this cycle
//   entry_ready   out  channel can accept a token (not full)
//   output_1      out  head token (show-ahead, storage[rd_ptr])
//   output_valid  out  output_1 holds a valid token (not empty)
//   output_ready  in   consumer takes output_1 this cycle
//   count         out  tokens currently stored, 0..DEPTH
// -----------------------------------------------------------------------------
module kpn_fifo_channel #(
  parameter int unsigned            DATA_WIDTH  = 16,
  parameter int unsigned            DEPTH       = 8,
  parameter int unsigned            ADDR_WIDTH  = 3,
  parameter int unsigned            INIT_TOKENS = 0,
  parameter logic [DATA_WIDTH-1:0]  INIT_VALUE  = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] entry_1,
  input  logic                  entry_valid,
  output logic                  entry_ready,
  output logic [DATA_WIDTH-1:0] output_1,
  output logic                  output_valid,
  input  logic                  output_ready,
  output logic [ADDR_WIDTH:0]   count
);

  localparam int unsigned CNT_W = ADDR_WIDTH + 1;

  // Reset values of the pointers and occupancy, derived from the seed tokens.
  // The write pointer starts just past the last seed token and wraps at DEPTH.
  localparam logic [ADDR_WIDTH-1:0] INIT_WR_PTR = ADDR_WIDTH'(INIT_TOKENS % DEPTH);
  localparam logic [CNT_W-1:0]      INIT_COUNT  = CNT_W'(INIT_TOKENS);
  localparam logic [CNT_W-1:0]      FULL_COUNT  = CNT_W'(DEPTH);

  // Storage, pointers, and occupancy.
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]      count_q,  count_d;

  logic push;
  logic pop;

  // Full and empty come from the occupancy count. When rd_ptr == wr_ptr, the
  // pointers alone cannot tell a full channel from an empty one.
  assign entry_ready  = (count_q != FULL_COUNT);
  assign output_valid = (count_q != '0);

  // A push is refused while the channel is full, even when a pop takes place in
  // the same cycle. The producer keeps entry_valid high and retries later.
  assign push = entry_valid  && entry_ready;
  assign pop  = output_valid && output_ready;

  // Show-ahead read: the head token is visible without a read strobe.
  assign output_1 = mem_q[rd_ptr_q];
  assign count    = count_q;

  // Next-state logic for the pointers and occupancy.
  // NOTE: every signal gets its default before any condition. Without that, a
  // path that skips the assignment would infer a latch.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;

    if (push) wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);

    // A push and a pop in the same cycle leave the occupancy unchanged.
    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state updates use non-blocking assignments. This lets all
  // registers sample the values from before the edge, whatever the block order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= INIT_WR_PTR;
      count_q  <= INIT_COUNT;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: the storage array is reset on purpose. The seed tokens have to be in
  // place as soon as reset is applied, and output_1 must read a defined value
  // (0 when there are no seed tokens) instead of an uninitialised word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= (i < INIT_TOKENS) ? INIT_VALUE : '0;
      end
    end else if (push) begin
      mem_q[wr_ptr_q] <= entry_1;
    end
  end

endmodule

// File: tb/tb_kpn_fifo_channel.sv
// -----------------------------------------------------------------------------
// tb_kpn_fifo_channel
//
// Self-checking bench for kpn_fifo_channel. The main instance uses the default
// parameters. A second instance is seeded with two tokens of value 7. A
// queue-based token model predicts occupancy, handshake flags, and the head
// token. Directed scenarios run first, then randomised traffic.
// -----------------------------------------------------------------------------
module tb_kpn_fifo_channel;

  localparam int DW    = 16;
  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic          clk = 1'b0;
  logic          reset;

  // Main instance (no seed tokens)
  logic [DW-1:0] entry_1;
  logic          entry_valid;
  logic          entry_ready;
  logic [DW-1:0] output_1;
  logic          output_valid;
  logic          output_ready;
  logic [AW:0]   count;

  // Seeded instance (INIT_TOKENS=2, INIT_VALUE=7)
  logic [DW-1:0] s_entry_1;
  logic          s_entry_valid;
  logic          s_entry_ready;
  logic [DW-1:0] s_output_1;
  logic          s_output_valid;
  logic          s_output_ready;
  logic [AW:0]   s_count;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: the tokens currently held, oldest first.
  logic [DW-1:0] model_q [$];
  // Tokens the consumer actually received from the main instance.
  logic [DW-1:0] popped_q [$];

  kpn_fifo_channel #(
    .DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW),
    .INIT_TOKENS(0), .INIT_VALUE(16'd0)
  ) dut (
    .clk(clk), .reset(reset),
    .entry_1(entry_1), .entry_valid(entry_valid), .entry_ready(entry_ready),
    .output_1(output_1), .output_valid(output_valid), .output_ready(output_ready),
    .count(count)
  );

  kpn_fifo_channel #(
    .DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW),
    .INIT_TOKENS(2), .INIT_VALUE(16'd7)
  ) dut_seeded (
    .clk(clk), .reset(reset),
    .entry_1(s_entry_1), .entry_valid(s_entry_valid), .entry_ready(s_entry_ready),
    .output_1(s_output_1), .output_valid(s_output_valid), .output_ready(s_output_ready),
    .count(s_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Compare every visible output of the main instance against the model.
  task automatic check_model(input string tag);
    check({tag, ".count"}, 32'(count), 32'(model_q.size()));
    check({tag, ".entry_ready"}, 32'(entry_ready), 32'(model_q.size() < DEPTH));
    check({tag, ".output_valid"}, 32'(output_valid), 32'(model_q.size() > 0));
    if (model_q.size() > 0) check({tag, ".head"}, 32'(output_1), 32'(model_q[0]));
  endtask

  // Apply one clock cycle of producer/consumer activity to the main instance.
  // Inputs are driven 1 time unit after an edge and outputs are sampled there.
  task automatic cycle(input string tag, input logic [DW-1:0] d,
                       input bit push, input bit pop);
    bit do_push;
    bit do_pop;
    entry_1      = d;
    entry_valid  = push;
    output_ready = pop;
    do_pop  = pop  && (model_q.size() > 0);
    do_push = push && (model_q.size() < DEPTH);
    if (do_pop) popped_q.push_back(output_1);
    @(posedge clk);
    if (do_pop)  void'(model_q.pop_front());
    if (do_push) model_q.push_back(d);
    #1;
    entry_valid  = 1'b0;
    output_ready = 1'b0;
    check_model(tag);
  endtask

  initial begin
    int pp;
    int qp;
    reset          = 1'b1;
    entry_1        = '0;
    entry_valid    = 1'b0;
    output_ready   = 1'b0;
    s_entry_1      = '0;
    s_entry_valid  = 1'b0;
    s_output_ready = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;

    // 1: reset defaults, then a single push becomes visible one cycle later.
    check("t1.count_rst", 32'(count), 32'd0);
    check("t1.valid_rst", 32'(output_valid), 32'd0);
    check("t1.ready_rst", 32'(entry_ready), 32'd1);
    cycle("t1.push", 16'd1500, 1'b1, 1'b0);
    check("t1.out", 32'(output_1), 32'd1500);
    check("t1.valid", 32'(output_valid), 32'd1);
    check("t1.count", 32'(count), 32'd1);
    cycle("t1.pop", 16'd0, 1'b0, 1'b1);

    // 5: the seeded instance starts with two tokens of value 7.
    check("t5.count_rst", 32'(s_count), 32'd2);
    check("t5.out_rst", 32'(s_output_1), 32'd7);
    check("t5.valid_rst", 32'(s_output_valid), 32'd1);
    s_output_ready = 1'b1;
    @(posedge clk); #1;
    check("t5.pop1_out", 32'(s_output_1), 32'd7);
    check("t5.pop1_count", 32'(s_count), 32'd1);
    s_entry_1     = 16'd55;
    s_entry_valid = 1'b1;
    @(posedge clk); #1;
    s_entry_valid = 1'b0;
    check("t5.pop2_out", 32'(s_output_1), 32'd55);
    check("t5.pop2_count", 32'(s_count), 32'd1);
    @(posedge clk); #1;
    s_output_ready = 1'b0;
    check("t5.pop3_count", 32'(s_count), 32'd0);
    check("t5.pop3_valid", 32'(s_output_valid), 32'd0);

    // 2: fill to capacity, attempt an extra push, then drain in order.
    for (int i = 1; i <= DEPTH; i++) cycle("t2.fill", 16'(i), 1'b1, 1'b0);
    check("t2.count_full", 32'(count), 32'd8);
    check("t2.ready_full", 32'(entry_ready), 32'd0);
    cycle("t2.refused", 16'd9, 1'b1, 1'b0);
    check("t2.count_after_refuse", 32'(count), 32'd8);
    popped_q.delete();
    for (int i = 1; i <= DEPTH; i++) cycle("t2.drain", 16'd0, 1'b0, 1'b1);
    for (int i = 0; i < DEPTH; i++)
      check("t2.order", 32'(popped_q[i]), 32'(i + 1));
    check("t2.count_empty", 32'(count), 32'd0);
    check("t2.valid_empty", 32'(output_valid), 32'd0);

    // 3: stream 100..119 with a push and a pop every cycle. This writes 20
    //    words, so both pointers wrap more than twice.
    popped_q.delete();
    cycle("t3.prime", 16'd100, 1'b1, 1'b0);
    for (int k = 101; k <= 119; k++) begin
      cycle("t3.stream", 16'(k), 1'b1, 1'b1);
      check("t3.count_const", 32'(count), 32'd1);
    end
    cycle("t3.flush", 16'd0, 1'b0, 1'b1);
    check("t3.npopped", 32'(popped_q.size()), 32'd20);
    for (int k = 0; k < 20; k++)
      check("t3.seq", 32'(popped_q[k]), 32'(100 + k));

    // 4: with the FIFO full, a simultaneous push and pop pops but refuses the
    //    push. The refused token must never come out.
    for (int i = 0; i < DEPTH; i++) cycle("t4.fill", 16'(200 + i), 1'b1, 1'b0);
    popped_q.delete();
    cycle("t4.full_pushpop", 16'd999, 1'b1, 1'b1);
    check("t4.count", 32'(count), 32'd7);
    for (int i = 0; i < 7; i++) cycle("t4.drain", 16'd0, 1'b0, 1'b1);
    check("t4.npopped", 32'(popped_q.size()), 32'd8);
    for (int i = 0; i < 8; i++)
      check("t4.seq", 32'(popped_q[i]), 32'(200 + i));
    check("t4.count_empty", 32'(count), 32'd0);

    // 6: reset in the middle of traffic clears the channel without a clock edge.
    for (int i = 0; i < 5; i++) cycle("t6.fill", 16'(300 + i), 1'b1, 1'b0);
    check("t6.count5", 32'(count), 32'd5);
    #1 reset = 1'b1;
    #1;
    check("t6.count_async", 32'(count), 32'd0);
    check("t6.valid_async", 32'(output_valid), 32'd0);
    check("t6.seeded_count_async", 32'(s_count), 32'd2);
    model_q.delete();
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    check_model("t6.after_release");
    cycle("t6.push", 16'd400, 1'b1, 1'b0);
    check("t6.first_out", 32'(output_1), 32'd400);
    popped_q.delete();
    cycle("t6.pop", 16'd0, 1'b0, 1'b1);
    check("t6.first_read", 32'(popped_q[0]), 32'd400);

    // Randomised traffic. Three phases bias toward filling, balanced traffic,
    // and draining, so that the full, empty, and wrap-around cases recur.
    for (int ph = 0; ph < 3; ph++) begin
      pp = (ph == 0) ? 80 : (ph == 1) ? 50 : 25;
      qp = (ph == 0) ? 25 : (ph == 1) ? 50 : 80;
      for (int n = 0; n < 250; n++)
        cycle("rand", 16'($urandom_range(0, 65535)),
              $urandom_range(0, 99) < pp, $urandom_range(0, 99) < qp);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
